// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-lane-writable register memory.
// Adds a fixed number of wait states and flags misaligned or out-of-range accesses.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WIDTH   = 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2,
    localparam int STRB_SIZE  = DATA_WIDTH / MEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  enable,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_SIZE-1:0]  strobe,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  slverr
);

    localparam int OFF_W = $clog2(STRB_SIZE);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]            cnt;
    logic                  capture;
    logic                  cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_SIZE-1:0]  strobe_q;
    logic                  write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      widx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  err;
    logic                  do_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cnt_inc    = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                // enable without a prior setup phase is ignored
                if (sel && !enable) begin
                    capture    = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!sel) begin
                    state_next = IDLE;
                end else if (enable) begin
                    if (cnt == WAIT_LIMIT) begin
                        ready      = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            write_q  <= 1'b0;
        end else if (capture) begin
            cnt      <= '0;
            addr_q   <= addr;
            wdata_q  <= wdata;
            strobe_q <= strobe;
            write_q  <= write;
        end else if (cnt_inc) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign word_idx     = addr_q >> OFF_W;
    assign widx         = word_idx[IDX_W-1:0];
    assign misaligned   = (addr_q[OFF_W-1:0] != '0);
    assign out_of_range = (int'(word_idx) >= MEM_DEPTH);
    assign err          = misaligned || out_of_range;
    assign do_write     = ready && write_q && !err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned w = 0; w < MEM_DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (do_write) begin
            for (int unsigned i = 0; i < STRB_SIZE; i++) begin
                if (strobe_q[i]) begin
                    mem[widx][MEM_WIDTH*i +: MEM_WIDTH] <= wdata_q[MEM_WIDTH*i +: MEM_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rdata  = '0;
        slverr = ready && err;
        if (ready && !write_q && !err) begin
            rdata = mem[widx];
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with two wait states, one with none.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        enable = 1'b0;
    logic        write = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  strobe = '0;
    logic        tgt = 1'b0;

    logic        sel_a, sel_b;
    logic        ready_a, ready_b, slverr_a, slverr_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sel_a = sel & ~tgt;
    assign sel_b = sel & tgt;

    apb_slave_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .sel(sel_a), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .strobe(strobe),
        .ready(ready_a), .rdata(rdata_a), .slverr(slverr_a)
    );

    apb_slave_mem #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .sel(sel_b), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .strobe(strobe),
        .ready(ready_b), .rdata(rdata_b), .slverr(slverr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cur_ready();
        return tgt ? ready_b : ready_a;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the ready edge with the bus still driven.
    task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int waits);
        logic done;
        sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d; strobe = s;
        @(posedge clk); #1;
        enable = 1'b1;
        addr = ~a; wdata = ~d;
        waits = 0; rd = '0; er = 1'b0; done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            waits++;
            if (cur_ready()) begin
                rd = tgt ? rdata_b : rdata_a;
                er = tgt ? slverr_b : slverr_a;
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        sel = 1'b0; enable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          w;
    int          c0;

    initial begin
        #2;
        @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_slverr", 32'(slverr_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(1'b0, 10'h000, 32'h0, 4'h0, rd, er, w); idle();
        check("rd0_waits", 32'(w), 32'd3);
        check("rd0_data", rd, 32'h0);
        check("rd0_err", 32'(er), 32'd0);

        c0 = cyc;
        xfer(1'b1, 10'h004, 32'hDEADBEEF, 4'hF, rd, er, w);
        check("wr4_rdata0", rd, 32'h0);
        check("wr4_err", 32'(er), 32'd0);
        xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, w);
        check("b2b_cycles", 32'(cyc - c0), 32'd8);
        idle();
        check("rd4_data", rd, 32'hDEADBEEF);

        xfer(1'b1, 10'h008, 32'h11223344, 4'hF, rd, er, w);
        xfer(1'b1, 10'h008, 32'hAABBCCDD, 4'h3, rd, er, w);
        xfer(1'b0, 10'h008, 32'h0, 4'h0, rd, er, w); idle();
        check("strobe3_data", rd, 32'h1122CCDD);

        xfer(1'b1, 10'h008, 32'h99999999, 4'h0, rd, er, w);
        xfer(1'b0, 10'h008, 32'h0, 4'hF, rd, er, w); idle();
        check("strobe0_data", rd, 32'h1122CCDD);

        xfer(1'b0, 10'h005, 32'h0, 4'h0, rd, er, w);
        check("misal_err", 32'(er), 32'd1);
        check("misal_data", rd, 32'h0);
        xfer(1'b1, 10'h0FC, 32'h5A5A5A5A, 4'hF, rd, er, w);
        xfer(1'b0, 10'h0FC, 32'h0, 4'h0, rd, er, w);
        check("w63_err", 32'(er), 32'd0);
        check("w63_data", rd, 32'h5A5A5A5A);
        xfer(1'b1, 10'h100, 32'hFFFFFFFF, 4'hF, rd, er, w);
        check("w64_err", 32'(er), 32'd1);
        xfer(1'b0, 10'h000, 32'h0, 4'h0, rd, er, w); idle();
        check("w64_alias_w0", rd, 32'h0);

        // abort after one enable cycle
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 10'h00C; wdata = 32'h12345678; strobe = 4'hF;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready_a), 32'd0);
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        xfer(1'b0, 10'h00C, 32'h0, 4'h0, rd, er, w); idle();
        check("abort_data", rd, 32'h0);
        check("abort_next_waits", 32'(w), 32'd3);

        // enable without setup is ignored
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 10'h004;
        repeat (4) begin
            @(negedge clk);
            check("proto_ready", 32'(ready_a), 32'd0);
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        xfer(1'b0, 10'h004, 32'h0, 4'h0, rd, er, w); idle();
        check("proto_next_waits", 32'(w), 32'd3);
        check("proto_next_data", rd, 32'hDEADBEEF);

        // reset during a wait state
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 10'h010; wdata = 32'hCAFEF00D; strobe = 4'hF;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstwait_ready", 32'(ready_a), 32'd0);
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 10'h010, 32'h0, 4'h0, rd, er, w); idle();
        check("rstwait_data", rd, 32'h0);

        // reset while ready is high
        sel = 1'b1; enable = 1'b0; write = 1'b0; addr = 10'h004; strobe = 4'h0;
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstrdy_pre", 32'(ready_a), 32'd1);
        rst = 1'b1;
        #1;
        check("rstrdy_ready", 32'(ready_a), 32'd0);
        check("rstrdy_rdata", rdata_a, 32'h0);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        @(posedge clk); #1;

        // zero wait states, back to back
        tgt = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            xfer(1'b1, 10'(4 * i), 32'h01010101 * (i + 1), 4'hF, rd, er, w);
            check("zw_waits", 32'(w), 32'd1);
        end
        check("zw_cycles", 32'(cyc - c0), 32'd20);
        xfer(1'b0, 10'h008, 32'h0, 4'h0, rd, er, w);
        check("zw_rd2", rd, 32'h03030303);
        xfer(1'b0, 10'h024, 32'h0, 4'h0, rd, er, w); idle();
        check("zw_rd9", rd, 32'h0A0A0A0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
